// File: rtl/inst_fetch.sv
// Instruction fetch: owns the fetch PC, drives a synchronous ROM and queues returned words in 2 entries.
// Latency: issue to InstValid is 2 cycles; a redirect in cycle t presents the target in t+3.
// Backpressure: InstReady low holds the head; issue stops once queued + in-flight reaches 2.
// Optional: define FETCH_PERF_EN to add the FetchCnt/StallCnt performance counters.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 6
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Redirect,
   input  logic [31:0]       RedirectPC,
   output logic              RomEn,
   output logic [ADDR_W-1:0] RomAddr,
   input  logic [31:0]       RomData,
   output logic              InstValid,
   input  logic              InstReady,
   output logic [31:0]       PC,
   output logic [31:0]       Inst
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       FetchCnt,
   output logic [31:0]       StallCnt
`endif
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic [31:0] fpc_q, fpc_d;
   logic        infl_q, infl_d;
   logic [31:0] infl_pc_q, infl_pc_d;
   logic [1:0]  cnt_q, cnt_d;
   entry_t      slot0_q, slot0_d;
   entry_t      slot1_q, slot1_d;

   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  occ;
   entry_t      new_e;

   // Handshake, issue decision and next-state for PC, in-flight tracker and queue
   always_comb begin
      pop       = (cnt_q != 2'd0) & InstReady;
      push      = infl_q & ~Redirect;
      // Occupancy after this cycle's pop; issuing only when it is <= 1 keeps every push in bounds
      occ       = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
      issue     = ~Rst & ~Redirect & (occ <= 3'd1);
      new_e     = '{pc: infl_pc_q, inst: RomData};

      fpc_d     = fpc_q;
      infl_d    = issue;
      infl_pc_d = infl_pc_q;
      cnt_d     = cnt_q;
      slot0_d   = slot0_q;
      slot1_d   = slot1_q;

      if (issue) begin
         fpc_d     = fpc_q + 32'd4;
         infl_pc_d = fpc_q;
      end

      // slot0 is always the head, so PC/Inst come straight from flops
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) slot0_d = new_e;
            else               slot1_d = new_e;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               slot0_d = new_e;
            end else begin
               slot0_d = slot1_q;
               slot1_d = new_e;
            end
         end
         default: ;
      endcase

      // Redirect squashes queued and in-flight words; a same-cycle transfer has already been delivered
      if (Redirect) begin
         cnt_d = 2'd0;
         fpc_d = RedirectPC & 32'hFFFF_FFFC;
      end
   end

   // State registers; reset wins over redirect and drops the queue and in-flight fetch on the same edge
   always_ff @(posedge Clk) begin
      if (Rst) begin
         fpc_q     <= RESET_PC;
         infl_q    <= 1'b0;
         infl_pc_q <= RESET_PC;
         cnt_q     <= 2'd0;
         slot0_q   <= '{pc: RESET_PC, inst: 32'd0};
         slot1_q   <= '0;
      end else begin
         fpc_q     <= fpc_d;
         infl_q    <= infl_d;
         infl_pc_q <= infl_pc_d;
         cnt_q     <= cnt_d;
         slot0_q   <= slot0_d;
         slot1_q   <= slot1_d;
      end
   end

   assign RomEn     = issue;
   assign RomAddr   = fpc_q[ADDR_W+1:2];
   assign InstValid = (cnt_q != 2'd0);
   assign PC        = slot0_q.pc;
   assign Inst      = slot0_q.inst;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count delivered instructions and cycles where decode is holding off a valid instruction
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (pop)                    fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (InstValid & ~InstReady) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Counter registers, wrapping naturally at 2^32
   always_ff @(posedge Clk) begin
      if (Rst) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign FetchCnt = fetch_cnt_q;
   assign StallCnt = stall_cnt_q;
`endif

endmodule
